// File: rtl/pio_irq_servicer_if.sv
// Bus bundle between the IRQ servicer, the edge-capture PIO slave port and
// the downstream event consumer.
interface pio_irq_servicer_if #(
  parameter int WIDTH = 2
);
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata,
    output evt_valid, evt_data,
    input  evt_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata,
    input  evt_valid, evt_data,
    output evt_ready
  );
endinterface

// File: rtl/pio_irq_servicer.sv
// Avalon-MM master that programs an edge-capture PIO's irq_mask, services its
// interrupt by reading and clearing edge_capture, and hands the captured bits
// to a consumer over a valid/ready handshake.
module pio_irq_servicer #(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] INIT_MASK = 2'b11,
  parameter int               HOLDOFF   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_irq_servicer_if.master   bus,
  input  logic                 pio_irq,
  input  logic [WIDTH-1:0]     mask_value,
  input  logic                 mask_update,
  output logic                 evt_overflow,
  output logic [15:0]          evt_count
);

  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int         HW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_MASK,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_CLR
  } state_t;

  state_t           state, state_next;
  logic             mask_pending;
  logic [WIDTH-1:0] mask_latched;
  logic [HW-1:0]    holdoff_cnt;
  logic [WIDTH-1:0] cap;
  logic             evt_valid_q;
  logic [WIDTH-1:0] evt_data_q;

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_data  = evt_data_q;

  // State register; reset parks the sequencer in INIT so the mask is rewritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_next;
  end

  // Next-state: a pending mask rewrite beats IRQ service, and IRQs wait out the holdoff.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:    state_next = ST_IDLE;
      ST_IDLE: begin
        if (mask_pending)                        state_next = ST_MASK;
        else if (pio_irq && (holdoff_cnt == '0)) state_next = ST_RD_ADDR;
      end
      ST_MASK:    state_next = ST_IDLE;
      ST_RD_ADDR: state_next = ST_RD_WAIT;
      ST_RD_WAIT: state_next = ST_CLR;
      ST_CLR:     state_next = ST_IDLE;
      default:    state_next = ST_INIT;
    endcase
  end

  // Bus decode from state; forced idle while reset is held so the bus goes quiet at once.
  always_comb begin
    bus.avm_address    = 2'd0;
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    bus.avm_writedata  = 32'd0;
    if (reset_n) begin
      case (state)
        ST_INIT: begin
          bus.avm_address    = ADDR_MASK;
          bus.avm_chipselect = 1'b1;
          bus.avm_write_n    = 1'b0;
          bus.avm_writedata  = 32'(INIT_MASK);
        end
        ST_MASK: begin
          bus.avm_address    = ADDR_MASK;
          bus.avm_chipselect = 1'b1;
          bus.avm_write_n    = 1'b0;
          bus.avm_writedata  = 32'(mask_latched);
        end
        ST_RD_ADDR: begin
          bus.avm_address    = ADDR_EDGE;
          bus.avm_chipselect = 1'b1;
        end
        ST_RD_WAIT: begin
          bus.avm_address    = ADDR_EDGE;
        end
        ST_CLR: begin
          bus.avm_address    = ADDR_EDGE;
          bus.avm_chipselect = 1'b1;
          bus.avm_write_n    = 1'b0;
        end
        default: begin
          bus.avm_address    = 2'd0;
        end
      endcase
    end
  end

  // Mask request latch; a fresh pulse wins over the MASK-state clear so it is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_pending <= 1'b0;
      mask_latched <= '0;
    end else if (mask_update) begin
      mask_pending <= 1'b1;
      mask_latched <= mask_value;
    end else if (state == ST_MASK) begin
      mask_pending <= 1'b0;
    end
  end

  // Holdoff counter: reloaded by every clear, counts down only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   holdoff_cnt <= '0;
    else if (state == ST_CLR)                       holdoff_cnt <= HW'(HOLDOFF);
    else if (state == ST_IDLE && holdoff_cnt != '0) holdoff_cnt <= holdoff_cnt - 1'b1;
  end

  // Capture the registered edge_capture readback in the cycle after the read address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cap <= '0;
    else if (state == ST_RD_WAIT) cap <= bus.avm_readdata[WIDTH-1:0];
  end

  // Event delivery: fresh load when the slot is empty or being accepted, OR-merge otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      evt_overflow <= 1'b0;
      evt_count    <= 16'd0;
    end else begin
      if (evt_valid_q && bus.evt_ready) evt_valid_q <= 1'b0;
      if (state == ST_CLR && cap != '0) begin
        if (!evt_valid_q || bus.evt_ready) begin
          evt_data_q  <= cap;
          evt_valid_q <= 1'b1;
        end else begin
          evt_data_q   <= evt_data_q | cap;
          evt_overflow <= 1'b1;
        end
        if (evt_count != 16'hFFFF) evt_count <= evt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Directed bench for pio_irq_servicer with a small edge-capture PIO model.
module tb_pio_irq_servicer;

  logic        clk;
  logic        reset_n;
  logic        pio_irq;
  logic [1:0]  mask_value;
  logic        mask_update;
  logic        evt_overflow;
  logic [15:0] evt_count;
  logic [1:0]  in_port;

  logic [1:0]  pio_mask;
  logic [1:0]  pio_ecap;
  logic [1:0]  in_d;

  int checks;
  int errors;

  pio_irq_servicer_if #(.WIDTH(2)) bus_if ();

  pio_irq_servicer #(.WIDTH(2), .INIT_MASK(2'b11), .HOLDOFF(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if.master),
    .pio_irq      (pio_irq),
    .mask_value   (mask_value),
    .mask_update  (mask_update),
    .evt_overflow (evt_overflow),
    .evt_count    (evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO slave model: rising-edge capture, write-to-clear, registered readdata.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_mask             <= 2'b00;
      pio_ecap             <= 2'b00;
      in_d                 <= 2'b00;
      bus_if.avm_readdata  <= 32'd0;
    end else begin
      in_d <= in_port;
      if (bus_if.avm_chipselect && !bus_if.avm_write_n && bus_if.avm_address == 2'd3)
        pio_ecap <= 2'b00;
      else
        pio_ecap <= pio_ecap | (in_port & ~in_d);
      if (bus_if.avm_chipselect && !bus_if.avm_write_n && bus_if.avm_address == 2'd2)
        pio_mask <= bus_if.avm_writedata[1:0];
      case (bus_if.avm_address)
        2'd0:    bus_if.avm_readdata <= {30'd0, in_port};
        2'd2:    bus_if.avm_readdata <= {30'd0, pio_mask};
        2'd3:    bus_if.avm_readdata <= {30'd0, pio_ecap};
        default: bus_if.avm_readdata <= 32'd0;
      endcase
    end
  end

  assign pio_irq = |(pio_ecap & pio_mask);

  typedef struct {
    logic [1:0]  edge_bits;
    logic        ready;
    logic [1:0]  exp_data;
    logic        exp_valid;
    logic        exp_ovf;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[6];

  function automatic logic isClear();
    return bus_if.avm_chipselect && !bus_if.avm_write_n && bus_if.avm_address == 2'd3;
  endfunction

  function automatic logic isRead();
    return bus_if.avm_chipselect && bus_if.avm_write_n && bus_if.avm_address == 2'd3;
  endfunction

  function automatic logic isMaskWrite();
    return bus_if.avm_chipselect && !bus_if.avm_write_n && bus_if.avm_address == 2'd2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Pulse the given in_port bits high for one cycle and set the consumer ready.
  task automatic applyStimulus(input logic [1:0] edge_bits, input logic ready);
    bus_if.evt_ready = ready;
    in_port          = edge_bits;
    @(negedge clk);
    in_port          = 2'b00;
  endtask

  // Walk negedges until the edge_capture clear write appears; latency counts from pio_irq.
  task automatic waitForClear(output int lat, output logic seen);
    int irq_at;
    irq_at = -1;
    seen   = 1'b0;
    lat    = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (pio_irq && irq_at < 0) irq_at = n;
      if (isClear()) begin
        seen = 1'b1;
        lat  = n - irq_at;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " address"},    32'(bus_if.avm_address),    32'd0);
    checkOutput({tag, " chipselect"}, 32'(bus_if.avm_chipselect), 32'd0);
    checkOutput({tag, " write_n"},    32'(bus_if.avm_write_n),    32'd1);
    checkOutput({tag, " writedata"},  bus_if.avm_writedata,       32'd0);
    checkOutput({tag, " evt_valid"},  32'(bus_if.evt_valid),      32'd0);
    checkOutput({tag, " evt_data"},   32'(bus_if.evt_data),       32'd0);
    checkOutput({tag, " overflow"},   32'(evt_overflow),          32'd0);
    checkOutput({tag, " count"},      32'(evt_count),             32'd0);
  endtask

  task automatic checkInitWrite(input string tag);
    checkOutput({tag, " init cs"},   32'(bus_if.avm_chipselect), 32'd1);
    checkOutput({tag, " init wr_n"}, 32'(bus_if.avm_write_n),    32'd0);
    checkOutput({tag, " init addr"}, 32'(bus_if.avm_address),    32'd2);
    checkOutput({tag, " init data"}, bus_if.avm_writedata,       32'd3);
    @(negedge clk);
    checkOutput({tag, " idle cs"},   32'(bus_if.avm_chipselect), 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic rd;
    int   gap;
    int   mask_writes;
    int   mask_at;
    logic [31:0] mask_data;
    int   reads;

    vecs[0] = '{edge_bits: 2'b01, ready: 1'b1, exp_data: 2'b01, exp_valid: 1'b1, exp_ovf: 1'b0, exp_count: 16'd1};
    vecs[1] = '{edge_bits: 2'b10, ready: 1'b1, exp_data: 2'b10, exp_valid: 1'b1, exp_ovf: 1'b0, exp_count: 16'd2};
    vecs[2] = '{edge_bits: 2'b11, ready: 1'b1, exp_data: 2'b11, exp_valid: 1'b1, exp_ovf: 1'b0, exp_count: 16'd3};
    vecs[3] = '{edge_bits: 2'b01, ready: 1'b0, exp_data: 2'b01, exp_valid: 1'b1, exp_ovf: 1'b0, exp_count: 16'd4};
    vecs[4] = '{edge_bits: 2'b10, ready: 1'b0, exp_data: 2'b11, exp_valid: 1'b1, exp_ovf: 1'b1, exp_count: 16'd5};
    vecs[5] = '{edge_bits: 2'b10, ready: 1'b1, exp_data: 2'b10, exp_valid: 1'b1, exp_ovf: 1'b1, exp_count: 16'd6};

    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    in_port          = 2'b00;
    mask_value       = 2'b00;
    mask_update      = 1'b0;
    bus_if.evt_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset_n = 1'b1;
    #1;
    checkInitWrite("boot");
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].edge_bits, vecs[i].ready);
      waitForClear(lat, seen);
      checkOutput($sformatf("v%0d clear_seen", i), 32'(seen), 32'd1);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      @(negedge clk);
      checkOutput($sformatf("v%0d evt_valid", i), 32'(bus_if.evt_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d evt_data", i),  32'(bus_if.evt_data),  32'(vecs[i].exp_data));
      checkOutput($sformatf("v%0d overflow", i),  32'(evt_overflow),     32'(vecs[i].exp_ovf));
      checkOutput($sformatf("v%0d count", i),     32'(evt_count),        32'(vecs[i].exp_count));
      repeat (10) @(negedge clk);
    end

    // Holdoff: second edge lands during holdoff and must wait for it to expire.
    applyStimulus(2'b01, 1'b0);
    waitForClear(lat, seen);
    checkOutput("holdoff first clear", 32'(seen), 32'd1);
    rd  = 1'b0;
    gap = -1;
    for (int g = 1; g <= 30 && !rd; g++) begin
      @(negedge clk);
      if (g == 2) in_port = 2'b10;
      if (g == 3) in_port = 2'b00;
      if (isRead()) begin
        rd  = 1'b1;
        gap = g;
      end
    end
    checkOutput("holdoff second read", 32'(rd), 32'd1);
    checkOutput("holdoff gap", 32'(gap), 32'd6);
    waitForClear(lat, seen);
    checkOutput("holdoff second clear", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("holdoff evt_data",  32'(bus_if.evt_data),  32'd3);
    checkOutput("holdoff evt_valid", 32'(bus_if.evt_valid), 32'd1);
    checkOutput("holdoff overflow",  32'(evt_overflow),     32'd1);
    checkOutput("holdoff count",     32'(evt_count),        32'd8);
    bus_if.evt_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Mask update: two pulses during service, only the last value is written afterwards.
    applyStimulus(2'b01, 1'b1);
    rd = 1'b0;
    for (int n = 0; n < 20 && !rd; n++) begin
      if (isRead()) rd = 1'b1;
      else @(negedge clk);
    end
    checkOutput("mask svc read", 32'(rd), 32'd1);
    mask_value  = 2'b01;
    mask_update = 1'b1;
    @(negedge clk);
    mask_value  = 2'b10;
    @(negedge clk);
    mask_update = 1'b0;
    checkOutput("mask svc clear", 32'(isClear()), 32'd1);
    mask_writes = 0;
    mask_at     = -1;
    mask_data   = 32'hFFFF_FFFF;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (isMaskWrite()) begin
        mask_writes++;
        if (mask_at < 0) begin
          mask_at   = j;
          mask_data = bus_if.avm_writedata;
        end
      end
    end
    checkOutput("mask write count", 32'(mask_writes), 32'd1);
    checkOutput("mask write slot",  32'(mask_at),     32'd2);
    checkOutput("mask write data",  mask_data,        32'd2);
    checkOutput("mask svc count",   32'(evt_count),   32'd9);
    applyStimulus(2'b01, 1'b1);
    reads = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (isRead()) reads++;
    end
    checkOutput("masked reads",     32'(reads),            32'd0);
    checkOutput("masked irq",       32'(pio_irq),          32'd0);
    checkOutput("masked count",     32'(evt_count),        32'd9);
    checkOutput("masked evt_valid", 32'(bus_if.evt_valid), 32'd0);

    // Reset asserted in the clear cycle: everything returns to reset values at once.
    applyStimulus(2'b10, 1'b1);
    waitForClear(lat, seen);
    checkOutput("rst clear seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkInitWrite("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
